// File: rtl/mont_mul_v2.sv
// Runtime-length radix-2 Montgomery multiplier: R = A*B*2^(-32*len) mod N.
// Operands are fetched word by word over the LSU port, reduced bit-serially
// (two cycles per bit), conditionally corrected, then written back.
// SQR mode reuses A as the B operand and skips the B fetch.

`ifndef DATA_WORD
`define DATA_WORD 2'b10
`endif

module mont_mul_v2 #(
  parameter int unsigned MAX_WORDS = 8,
  parameter int unsigned LEN_BITS  = $clog2(MAX_WORDS) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic [LEN_BITS-1:0] len_words,
  input  logic [31:0]         a_addr,
  input  logic [31:0]         b_addr,
  input  logic [31:0]         n_addr,
  input  logic [31:0]         res_addr,
  output logic                lsu_ren,
  output logic                lsu_wen,
  output logic [1:0]          lsu_type,
  output logic [31:0]         lsu_addr_base,
  output logic [31:0]         lsu_addr_offset,
  input  logic                lsu_done,
  input  logic [31:0]         lsu_rdata,
  output logic [31:0]         lsu_wdata,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned MaxBits = 32 * MAX_WORDS;
  // Two guard bits: M + B and M + N stay below 4N when A, B < N.
  localparam int unsigned MW      = MaxBits + 2;
  localparam int unsigned CntBits = $clog2(MaxBits) + 1;

  typedef enum logic [2:0] {
    StIdle, StFetch, StStepB, StStepN, StSub, StWrite, StDone, StErr
  } state_e;

  typedef enum logic [1:0] {PhA, PhB, PhN} phase_e;

  state_e              state_q;
  phase_e              phase_q;
  logic                mode_q;
  logic [LEN_BITS-1:0] len_q;
  logic [31:0]         a_addr_q, b_addr_q, n_addr_q, res_addr_q;
  logic [MaxBits-1:0]  a_q, b_q, n_q;
  logic [MW-1:0]       m_q;
  logic [CntBits-1:0]  cnt_q;
  logic [LEN_BITS-1:0] idx_q;
  logic                done_q, err_q;

  logic [LEN_BITS-2:0] idx_w;
  logic                last_word;
  logic                bad_len;
  logic                n_lsb;
  logic [MaxBits-1:0]  b_op;
  logic [MW-1:0]       m_plus_b;
  logic [MW-1:0]       m_odd_fix;
  logic [MW:0]         sub_sum;
  logic [CntBits-1:0]  bit_limit;
  logic [CntBits-1:0]  cnt_next;

  assign idx_w     = idx_q[LEN_BITS-2:0];
  assign last_word = (idx_q == len_q - LEN_BITS'(1));
  assign bad_len   = (len_words == '0) || (len_words > LEN_BITS'(MAX_WORDS));
  // The last N word is still on the bus when len == 1, so take bit 0 from there.
  assign n_lsb     = (idx_q == '0) ? lsu_rdata[0] : n_q[0];
  assign b_op      = mode_q ? a_q : b_q;
  assign m_plus_b  = m_q + {2'b00, b_op};
  assign m_odd_fix = m_q[0] ? (m_q + {2'b00, n_q}) : m_q;
  // M - N as M + ~N + 1; carry out set means M >= N.
  assign sub_sum   = {1'b0, m_q} + {1'b0, ~{2'b00, n_q}} + {{MW{1'b0}}, 1'b1};
  assign bit_limit = CntBits'({len_q, 5'b00000});
  assign cnt_next  = cnt_q + CntBits'(1);

  // Control FSM plus operand/accumulator datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      phase_q    <= PhA;
      mode_q     <= 1'b0;
      len_q      <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      n_addr_q   <= '0;
      res_addr_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      n_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (start) begin
            mode_q     <= mode;
            len_q      <= len_words;
            a_addr_q   <= a_addr;
            b_addr_q   <= b_addr;
            n_addr_q   <= n_addr;
            res_addr_q <= res_addr;
            if (bad_len) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              a_q     <= '0;
              b_q     <= '0;
              n_q     <= '0;
              m_q     <= '0;
              idx_q   <= '0;
              phase_q <= PhA;
              state_q <= StFetch;
            end
          end
        end

        StFetch: begin
          if (lsu_done) begin
            case (phase_q)
              PhA:     a_q[{idx_w, 5'b00000} +: 32] <= lsu_rdata;
              PhB:     b_q[{idx_w, 5'b00000} +: 32] <= lsu_rdata;
              default: n_q[{idx_w, 5'b00000} +: 32] <= lsu_rdata;
            endcase
            if (last_word) begin
              idx_q <= '0;
              case (phase_q)
                PhA:     phase_q <= mode_q ? PhN : PhB;
                PhB:     phase_q <= PhN;
                default: begin
                  if (n_lsb) begin
                    cnt_q   <= '0;
                    state_q <= StStepB;
                  end else begin
                    done_q  <= 1'b1;
                    err_q   <= 1'b1;
                    state_q <= StErr;
                  end
                end
              endcase
            end else begin
              idx_q <= idx_q + LEN_BITS'(1);
            end
          end
        end

        StStepB: begin
          // A is indexed rather than shifted so it survives for SQR's B view.
          if (a_q[cnt_q[CntBits-2:0]]) m_q <= m_plus_b;
          state_q <= StStepN;
        end

        StStepN: begin
          m_q   <= m_odd_fix >> 1;
          cnt_q <= cnt_next;
          state_q <= (cnt_next == bit_limit) ? StSub : StStepB;
        end

        StSub: begin
          if (sub_sum[MW]) m_q <= sub_sum[MW-1:0];
          idx_q   <= '0;
          state_q <= StWrite;
        end

        StWrite: begin
          if (lsu_done) begin
            if (last_word) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q <= idx_q + LEN_BITS'(1);
            end
          end
        end

        StDone, StErr: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          idx_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // LSU request decode; everything here derives from registered state.
  always_comb begin
    lsu_ren         = 1'b0;
    lsu_wen         = 1'b0;
    lsu_addr_base   = '0;
    lsu_addr_offset = '0;
    lsu_wdata       = '0;
    case (state_q)
      StFetch: begin
        lsu_ren         = 1'b1;
        lsu_addr_offset = {{(32-LEN_BITS-2){1'b0}}, idx_q, 2'b00};
        case (phase_q)
          PhA:     lsu_addr_base = a_addr_q;
          PhB:     lsu_addr_base = b_addr_q;
          default: lsu_addr_base = n_addr_q;
        endcase
      end
      StWrite: begin
        lsu_wen         = 1'b1;
        lsu_addr_base   = res_addr_q;
        lsu_addr_offset = {{(32-LEN_BITS-2){1'b0}}, idx_q, 2'b00};
        lsu_wdata       = m_q[{idx_w, 5'b00000} +: 32];
      end
      default: ;
    endcase
  end

  assign lsu_type = `DATA_WORD;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: doc/mont_mul_v2.md
Name: mont_mul_v2

Overview:
- Runtime-length radix-2 Montgomery multiplier: computes R = A·B·2^(-32·len) mod N for operands of 1..MAX_WORDS 32-bit words.
- Operands are fetched from memory and the result is written back through the core LSU port.
- Adds two things fixed-width units do not have: a SQR mode that reuses A as B and skips the B fetch, and error reporting for a bad length or an even modulus.
- Sits beside the RISC-V core as a memory-mapped accelerator driven by a custom instruction.

Parameters:
- MAX_WORDS, 8, maximum operand length in 32-bit words; power of two, ≥2.
- LEN_BITS, $clog2(MAX_WORDS)+1, width of the len_words input.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- start  input  1  one-cycle request, sampled only in IDLE
- mode  input  1  0 = MUL (R = A·B·2^-k mod N), 1 = SQR (R = A·A·2^-k mod N)
- len_words  input  LEN_BITS  operand length in words
- a_addr  input  32  word-aligned base address of A
- b_addr  input  32  word-aligned base address of B (ignored in SQR)
- n_addr  input  32  word-aligned base address of N
- res_addr  input  32  word-aligned base address of result
- lsu_ren  output  1  read request
- lsu_wen  output  1  write request
- lsu_type  output  2  constant `DATA_WORD
- lsu_addr_base  output  32  access base address
- lsu_addr_offset  output  32  byte offset = word_index·4
- lsu_done  input  1  access complete; read data valid in the same cycle
- lsu_rdata  input  32  read data
- lsu_wdata  output  32  write data
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on completion
- err  output  1  one-cycle pulse, coincident with done, on error

Behaviour:
- Reset (asynchronous, active-low; clock clk):
  - State IDLE; all outputs 0; operand registers, M and counters cleared.
  - Reset asserted mid-operation aborts immediately. No further LSU activity; nothing partial is completed.
- IDLE:
  - On start, latch mode, len_words and all four addresses together.
  - len_words==0 or len_words>MAX_WORDS: next cycle pulse done=err=1, stay IDLE, no LSU access.
  - Otherwise go to FETCH, clearing A/B/N/M; words at index ≥len stay 0.
- FETCH:
  - Sequence is A[0..len-1], then B[0..len-1] (skipped in SQR), then N[0..len-1].
  - lsu_ren is held high and address stable until lsu_done. Word is captured on lsu_done, then the next address is presented the following cycle.
  - One access is outstanding at a time.
  - After the last N word: if N[0]==0, go to ERR (pulse done=err=1, then IDLE, no writes); else go to STEP_B with bit counter = 0.
  - In SQR mode the B operand is A everywhere.
- STEP_B: if A bit[counter] = 1, M ← M + B. Go to STEP_N.
- STEP_N:
  - If M odd, M ← M + N; then M ← M >> 1; counter+1.
  - If counter reaches 32·len, go to SUB; else go to STEP_B.
  - Each bit costs 2 cycles; compute latency is 64·len cycles.
  - A bit is selected by index (A is not shifted), so A stays intact.
- SUB: if M ≥ N, M ← M − N (single adder, carry-in 1, ~N). Go to WRITE with word index 0.
- WRITE:
  - lsu_wen high, lsu_addr_base = res_addr, offset = idx·4, lsu_wdata = M word idx; all held until lsu_done.
  - After write len-1 completes, go to DONE.
- DONE: done=1, err=0 for one cycle; return to IDLE.
- Width and arithmetic:
  - M is MAX_BITS+2 bits (MAX_BITS = 32·MAX_WORDS).
  - With A, B < N the invariant M < 2N holds, so no overflow occurs.
  - Inputs with A ≥ N or B ≥ N give unspecified results but must still terminate normally.
- Further rules:
  - start while busy is ignored.
  - lsu_done outside FETCH/WRITE is ignored.
  - lsu_done may arrive in the same cycle the request is raised (zero-wait memory); the next request follows one cycle later.

Test Plan:
- MUL, len=1, A=5, B=7, N=13 -> one word 0x00000001 written at res_addr; done pulse; err=0; exactly 3 reads and 1 write.
- SQR, len=1, A=5, N=13 -> result 0x0000000A; only 2 reads (A, N); b_addr never driven.
- MUL, len=2, N=0xFFFFFFFF_FFFFFFC5, A=0x3B (R mod N), B=0x1234 -> result words 0x00001234, 0x00000000; 64·2 compute cycles measured between last read and first write (±2).
- len=0, then len=MAX_WORDS+1 -> done=err=1 one cycle after start; lsu_ren/lsu_wen never asserted.
- MUL, len=1, N=12 (even) -> 3 reads, then done=err=1; no write.
- Random lsu_done latency 0-5 cycles, len=MAX_WORDS, plus rst_n pulsed mid-STEP_B -> the delayed-handshake run matches the model; after reset outputs=0 and busy=0, and a new start completes correctly.
